// File: rtl/div_issue_arbiter.sv
// rtl/div_issue_arbiter.sv - shares one iterative divider between the two EX issue lanes
// Define DIV_ZERO_FAST_EN to return {dividend, 0} for a zero divisor without starting the divider.
module div_issue_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                req1_i,
  input  logic                signed1_i,
  input  logic [DATA_W-1:0]   op1a_i,
  input  logic [DATA_W-1:0]   op1b_i,
  input  logic                req2_i,
  input  logic                signed2_i,
  input  logic [DATA_W-1:0]   op2a_i,
  input  logic [DATA_W-1:0]   op2b_i,
  output logic                div_start_o,
  output logic                div_annul_o,
  output logic                div_signed_o,
  output logic [DATA_W-1:0]   div_opa_o,
  output logic [DATA_W-1:0]   div_opb_o,
  input  logic [2*DATA_W-1:0] div_result_i,
  input  logic                div_ready_i,
  output logic                res1_valid_o,
  output logic                res2_valid_o,
  output logic [DATA_W-1:0]   res_hi_o,
  output logic [DATA_W-1:0]   res_lo_o,
  output logic                stallreq_for_div
);

`ifdef DIV_ZERO_FAST_EN
  typedef enum logic [1:0] {IDLE, RUN, ZERO, DONE} state_e;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
`endif

  state_e            state_q;
  logic              owner2_q;
  logic              pend2_q;
  logic              done1_q, done2_q;
  logic              sgn_q, qsgn_q;
  logic [DATA_W-1:0] opa_q, opb_q;
  logic [DATA_W-1:0] qopa_q, qopb_q;
  logic [DATA_W-1:0] hi_q, lo_q;

  logic              done1_d, done2_d;
  logic              issue1, issue2;
  logic              in_run, in_done;
  logic              iss_sgn;
  logic [DATA_W-1:0] iss_a, iss_b;
  state_e            launch_st;

  assign in_run  = (state_q == RUN);
  assign in_done = (state_q == DONE);
  assign issue1  = req1_i & ~done1_q;
  assign issue2  = req2_i & ~done2_q;

  assign div_start_o  = in_run & ~flush;
  assign div_annul_o  = in_run & flush;
  assign div_signed_o = sgn_q;
  assign div_opa_o    = opa_q;
  assign div_opb_o    = opb_q;

  assign res1_valid_o = in_done & ~owner2_q & ~flush;
  assign res2_valid_o = in_done & owner2_q & ~flush;
  assign res_hi_o     = hi_q;
  assign res_lo_o     = lo_q;

  // A lane stops stalling in the cycle its own result is strobed.
  assign stallreq_for_div = ~flush &
                            ((req1_i & ~done1_q & ~res1_valid_o) |
                             (req2_i & ~done2_q & ~res2_valid_o));

  assign done1_d = (done1_q | res1_valid_o) & req1_i & ~flush;
  assign done2_d = (done2_q | res2_valid_o) & req2_i & ~flush;

  always_comb begin
    iss_sgn = signed1_i;
    iss_a   = op1a_i;
    iss_b   = op1b_i;
    if (!issue1) begin
      iss_sgn = signed2_i;
      iss_a   = op2a_i;
      iss_b   = op2b_i;
    end
  end

`ifdef DIV_ZERO_FAST_EN
  logic [DATA_W-1:0] launch_b;
  assign launch_b  = in_done ? qopb_q : iss_b;
  assign launch_st = (launch_b == '0) ? ZERO : RUN;
`else
  assign launch_st = RUN;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner2_q <= 1'b0;
      pend2_q  <= 1'b0;
      done1_q  <= 1'b0;
      done2_q  <= 1'b0;
      sgn_q    <= 1'b0;
      qsgn_q   <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      qopa_q   <= '0;
      qopb_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done1_q <= done1_d;
      done2_q <= done2_d;
      if (flush) begin
        state_q <= IDLE;
        pend2_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (issue1 | issue2) begin
              state_q  <= launch_st;
              owner2_q <= ~issue1;
              sgn_q    <= iss_sgn;
              opa_q    <= iss_a;
              opb_q    <= iss_b;
              pend2_q  <= issue1 & issue2;
              if (issue1 & issue2) begin
                qsgn_q <= signed2_i;
                qopa_q <= op2a_i;
                qopb_q <= op2b_i;
              end
            end
          end
          RUN: begin
            if (div_ready_i) begin
              hi_q    <= div_result_i[2*DATA_W-1:DATA_W];
              lo_q    <= div_result_i[DATA_W-1:0];
              state_q <= DONE;
            end
          end
`ifdef DIV_ZERO_FAST_EN
          ZERO: begin
            hi_q    <= opa_q;
            lo_q    <= '0;
            state_q <= DONE;
          end
`endif
          DONE: begin
            // Lane 2 was queued behind lane 1: launch it without passing through IDLE.
            if (pend2_q) begin
              state_q  <= launch_st;
              owner2_q <= 1'b1;
              pend2_q  <= 1'b0;
              sgn_q    <= qsgn_q;
              opa_q    <= qopa_q;
              opb_q    <= qopb_q;
            end else begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_issue_arbiter.sv
// tb/tb_div_issue_arbiter.sv - scoreboard bench for div_issue_arbiter with a behavioural divider
module tb_div_issue_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        req1_i = 1'b0, signed1_i = 1'b0, req2_i = 1'b0, signed2_i = 1'b0;
  logic [31:0] op1a_i = '0, op1b_i = '0, op2a_i = '0, op2b_i = '0;
  logic        div_start_o, div_annul_o, div_signed_o;
  logic [31:0] div_opa_o, div_opb_o;
  logic [63:0] div_result_i = '0;
  logic        div_ready_i = 1'b0;
  logic        res1_valid_o, res2_valid_o;
  logic [31:0] res_hi_o, res_lo_o;
  logic        stallreq_for_div;

  always #5 clk = ~clk;

  div_issue_arbiter #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req1_i(req1_i), .signed1_i(signed1_i), .op1a_i(op1a_i), .op1b_i(op1b_i),
    .req2_i(req2_i), .signed2_i(signed2_i), .op2a_i(op2a_i), .op2b_i(op2b_i),
    .div_start_o(div_start_o), .div_annul_o(div_annul_o), .div_signed_o(div_signed_o),
    .div_opa_o(div_opa_o), .div_opb_o(div_opb_o),
    .div_result_i(div_result_i), .div_ready_i(div_ready_i),
    .res1_valid_o(res1_valid_o), .res2_valid_o(res2_valid_o),
    .res_hi_o(res_hi_o), .res_lo_o(res_lo_o),
    .stallreq_for_div(stallreq_for_div)
  );

  typedef struct {
    logic        lane2;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   lat = 33;
  int   run_cnt = 0;
  int   start_cycles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic bit fast_zero(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
    return b == 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic exp_t mk_exp(input logic lane2, input logic s, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] r;
    e.lane2 = lane2;
    if (fast_zero(b)) begin
      e.hi = a;
      e.lo = '0;
    end else begin
      r = ref_div(s, a, b);
      e.hi = r[63:32];
      e.lo = r[31:0];
    end
    return e;
  endfunction

  // Behavioural divider: answers after lat consecutive start cycles, forgets on start drop.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (div_start_o) start_cycles++;
      if (div_start_o && !div_ready_i) begin
        run_cnt++;
        if (run_cnt >= lat) begin
          div_result_i = ref_div(div_signed_o, div_opa_o, div_opb_o);
          div_ready_i  = 1'b1;
        end
      end else begin
        div_ready_i = 1'b0;
        run_cnt     = 0;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && (res1_valid_o || res2_valid_o)) begin
        if (sb_q.size() == 0) begin
          check("unexpected_strobe", {62'd0, res1_valid_o, res2_valid_o}, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("strobe_lane", {62'd0, res1_valid_o, res2_valid_o}, e.lane2 ? 64'd1 : 64'd2);
          check("res_hi", res_hi_o, e.hi);
          check("res_lo", res_lo_o, e.lo);
        end
      end
    end
  end

  task automatic run_op(input bit r1, input bit s1, input logic [31:0] a1, input logic [31:0] b1,
                        input bit r2, input bit s2, input logic [31:0] a2, input logic [31:0] b2,
                        input int l);
    int exp_stall;
    int stall_n;
    bit dropped;
    lat = l;
    exp_stall = 1 + ((r1 && r2) ? 1 : 0);
    if (r1) begin
      sb_q.push_back(mk_exp(1'b0, s1, a1, b1));
      exp_stall += fast_zero(b1) ? 1 : l;
    end
    if (r2) begin
      sb_q.push_back(mk_exp(1'b1, s2, a2, b2));
      exp_stall += fast_zero(b2) ? 1 : l;
    end
    @(negedge clk);
    req1_i = r1; signed1_i = s1; op1a_i = a1; op1b_i = b1;
    req2_i = r2; signed2_i = s2; op2a_i = a2; op2b_i = b2;
    stall_n = 0;
    dropped = 1'b0;
    for (int c = 0; c < 300 && !dropped; c++) begin
      #1;
      if (stallreq_for_div) begin
        stall_n++;
        @(negedge clk);
      end else begin
        dropped = 1'b1;
      end
    end
    check("stall_cycles", stall_n, exp_stall);
    check("strobe_at_stall_drop", res1_valid_o | res2_valid_o, 1);
    req1_i = 1'b0;
    req2_i = 1'b0;
    @(negedge clk);
    #3;
    check("scoreboard_drained", sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {div_start_o, div_annul_o, div_signed_o, res1_valid_o, res2_valid_o, stallreq_for_div}, 0);
    check({tag, "_opa"}, div_opa_o, 0);
    check({tag, "_opb"}, div_opb_o, 0);
    check({tag, "_hi"}, res_hi_o, 0);
    check({tag, "_lo"}, res_lo_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bit r1, r2, s1, s2;
    logic [31:0] a1, b1, a2, b2;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("reset");

    run_op(1, 1, 32'd100, 32'd7, 0, 0, 0, 0, 33);
    run_op(1, 1, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 0, 5);
    run_op(1, 0, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 0, 5);
    run_op(1, 0, 32'd20, 32'd3, 1, 0, 32'd9, 32'd4, 33);

    // Flush ten cycles into RUN.
    lat = 33;
    @(negedge clk);
    req1_i = 1'b1; signed1_i = 1'b0; op1a_i = 32'd1000; op1b_i = 32'd3;
    repeat (11) @(negedge clk);
    #1;
    check("stall_in_run", stallreq_for_div, 1);
    flush = 1'b1;
    #1;
    check("flush_annul", div_annul_o, 1);
    check("flush_start", div_start_o, 0);
    check("flush_stall", stallreq_for_div, 0);
    check("flush_no_strobe", res1_valid_o | res2_valid_o, 0);
    @(negedge clk);
    flush = 1'b0;
    req1_i = 1'b0;
    #1;
    check("post_flush_annul", div_annul_o, 0);
    check("post_flush_start", div_start_o, 0);
    repeat (3) @(negedge clk);

    // Reset mid-RUN with lane 2 queued.
    @(negedge clk);
    req1_i = 1'b1; signed1_i = 1'b0; op1a_i = 32'd20; op1b_i = 32'd3;
    req2_i = 1'b1; signed2_i = 1'b0; op2a_i = 32'd9;  op2b_i = 32'd4;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    req1_i = 1'b0;
    req2_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("mid_run_reset");
    run_op(1, 0, 32'd77, 32'd5, 0, 0, 0, 0, 4);

`ifdef DIV_ZERO_FAST_EN
    start_cycles = 0;
    run_op(1, 0, 32'd55, 32'd0, 0, 0, 0, 0, 33);
    check("zero_no_start", start_cycles, 0);
`endif

    for (int i = 0; i < 25; i++) begin
      r1 = 1'($urandom_range(0, 1));
      r2 = 1'($urandom_range(0, 1));
      if (!r1 && !r2) r1 = 1'b1;
      s1 = 1'($urandom_range(0, 1));
      s2 = 1'($urandom_range(0, 1));
      a1 = $urandom;
      a2 = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 500));
      b1 = ($urandom_range(0, 2) == 0) ? $urandom : 32'($urandom_range(1, 20));
      b2 = ($urandom_range(0, 2) == 0) ? $urandom : 32'($urandom_range(1, 20));
`ifdef DIV_ZERO_FAST_EN
      if ($urandom_range(0, 5) == 0) b1 = '0;
      if ($urandom_range(0, 5) == 0) b2 = '0;
`endif
      if (!fast_zero(b1) && b1 == 0) b1 = 32'd1;
      if (!fast_zero(b2) && b2 == 0) b2 = 32'd1;
      if (s1 && a1 == 32'h8000_0000 && b1 == 32'hFFFF_FFFF) b1 = 32'd3;
      if (s2 && a2 == 32'h8000_0000 && b2 == 32'hFFFF_FFFF) b2 = 32'd3;
      run_op(r1, s1, a1, b1, r2, s2, a2, b2, int'($urandom_range(1, 12)));
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
